// File: rtl/fp_norm_pkg.sv
// Shared defaults and stage payload layout for the fp_normalize pipeline.
package fp_norm_pkg;

    localparam int unsigned DEF_WID  = 64;
    localparam int unsigned DEF_EXPW = 11;
    localparam int unsigned DEF_LZW  = $clog2(DEF_WID + 1);

    typedef struct packed {
        logic [DEF_WID-1:0]  man;
        logic [DEF_EXPW-1:0] exp;
        logic [DEF_LZW-1:0]  lz;
        logic                zero;
        logic                denorm;
    } fp_norm_stage_t;

endpackage

// File: rtl/fp_norm_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WID.
module fp_norm_lzc
    import fp_norm_pkg::*;
#(
    parameter int unsigned WID = DEF_WID,
    parameter int unsigned LZW = $clog2(WID + 1)
) (
    input  logic [WID-1:0] man_i,
    output logic [LZW-1:0] lz_o
);

    // Scanning upward, the last set bit seen is the most significant one.
    always_comb begin
        lz_o = LZW'(WID);
        for (int unsigned i = 0; i < WID; i++) begin
            if (man_i[i]) begin
                lz_o = LZW'(WID - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_normalize.sv
// Three-stage mantissa normalizer (register, count, shift/adjust) with valid/ready flow.
// Optional saturating zero/denorm beat counters under FP_NORMALIZE_STATS_EN.
module fp_normalize
    import fp_norm_pkg::*;
#(
    parameter int unsigned WID  = DEF_WID,
    parameter int unsigned EXPW = DEF_EXPW,
    parameter int unsigned LZW  = $clog2(WID + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [WID-1:0]  i_man,
    input  logic [EXPW-1:0] i_exp,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [WID-1:0]  o_man,
    output logic [EXPW-1:0] o_exp,
    output logic [LZW-1:0]  o_lz,
    output logic            o_zero,
    output logic            o_denorm
`ifdef FP_NORMALIZE_STATS_EN
    ,
    output logic [31:0]     o_cnt_zero,
    output logic [31:0]     o_cnt_denorm
`endif
);

    typedef struct packed {
        logic [WID-1:0]  man;
        logic [EXPW-1:0] exp;
        logic [LZW-1:0]  lz;
        logic            zero;
        logic            denorm;
    } stage_t;

    logic            s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
    logic [WID-1:0]  s1_man_q, s1_man_d, s2_man_q, s2_man_d;
    logic [EXPW-1:0] s1_exp_q, s1_exp_d, s2_exp_q, s2_exp_d;
    logic [LZW-1:0]  s2_lz_q, s2_lz_d, lz_c;
    stage_t          s3_q, s3_d, res_c;
    logic            s3_free, s2_free, s1_adv, s2_adv, i_fire, o_fire;
    logic [EXPW:0]   diff_c;
    logic [LZW-1:0]  sh_c;

    fp_norm_lzc #(.WID(WID), .LZW(LZW)) u_lzc (
        .man_i (s1_man_q),
        .lz_o  (lz_c)
    );

    // A stage is free when empty or when everything below it drains this cycle.
    always_comb begin
        s3_free = !s3_v_q || o_ready;
        s2_free = !s2_v_q || s3_free;
        s1_adv  = ce && s1_v_q && s2_free;
        s2_adv  = ce && s2_v_q && s3_free;
        i_ready = !s1_v_q || s1_adv;
        i_fire  = ce && i_valid && i_ready;
        o_fire  = ce && s3_v_q && o_ready;
    end

    always_comb begin
        diff_c = {1'b0, s2_exp_q} - (EXPW+1)'(s2_lz_q);
        sh_c   = (s2_exp_q == '0) ? '0 : LZW'(s2_exp_q - 1'b1);
        res_c  = '0;
        if (s2_lz_q == LZW'(WID)) begin
            res_c.lz   = s2_lz_q;
            res_c.zero = 1'b1;
        end else if (!diff_c[EXPW] && (diff_c != '0)) begin
            res_c.man = s2_man_q << s2_lz_q;
            res_c.exp = diff_c[EXPW-1:0];
            res_c.lz  = s2_lz_q;
        end else begin
            res_c.man    = s2_man_q << sh_c;
            res_c.lz     = sh_c;
            res_c.denorm = 1'b1;
        end
    end

    always_comb begin
        s1_v_d   = i_fire || (s1_v_q && !s1_adv);
        s2_v_d   = s1_adv || (s2_v_q && !s2_adv);
        s3_v_d   = s2_adv || (s3_v_q && !o_fire);
        s1_man_d = i_fire ? i_man : s1_man_q;
        s1_exp_d = i_fire ? i_exp : s1_exp_q;
        s2_man_d = s1_adv ? s1_man_q : s2_man_q;
        s2_exp_d = s1_adv ? s1_exp_q : s2_exp_q;
        s2_lz_d  = s1_adv ? lz_c : s2_lz_q;
        s3_d     = s2_adv ? res_c : s3_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s3_v_q   <= 1'b0;
            s1_man_q <= '0;
            s1_exp_q <= '0;
            s2_man_q <= '0;
            s2_exp_q <= '0;
            s2_lz_q  <= '0;
            s3_q     <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s2_v_q   <= s2_v_d;
            s3_v_q   <= s3_v_d;
            s1_man_q <= s1_man_d;
            s1_exp_q <= s1_exp_d;
            s2_man_q <= s2_man_d;
            s2_exp_q <= s2_exp_d;
            s2_lz_q  <= s2_lz_d;
            s3_q     <= s3_d;
        end
    end

    assign o_valid  = s3_v_q;
    assign o_man    = s3_q.man;
    assign o_exp    = s3_q.exp;
    assign o_lz     = s3_q.lz;
    assign o_zero   = s3_q.zero;
    assign o_denorm = s3_q.denorm;

`ifdef FP_NORMALIZE_STATS_EN
    logic [31:0] cnt_zero_q, cnt_zero_d, cnt_denorm_q, cnt_denorm_d;

    always_comb begin
        cnt_zero_d   = cnt_zero_q;
        cnt_denorm_d = cnt_denorm_q;
        if (o_fire && s3_q.zero && (cnt_zero_q != '1)) begin
            cnt_zero_d = cnt_zero_q + 32'd1;
        end
        if (o_fire && s3_q.denorm && (cnt_denorm_q != '1)) begin
            cnt_denorm_d = cnt_denorm_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_zero_q   <= '0;
            cnt_denorm_q <= '0;
        end else begin
            cnt_zero_q   <= cnt_zero_d;
            cnt_denorm_q <= cnt_denorm_d;
        end
    end

    assign o_cnt_zero   = cnt_zero_q;
    assign o_cnt_denorm = cnt_denorm_q;
`endif

endmodule

// File: tb/tb_fp_normalize.sv
// Randomized self-checking bench for fp_normalize against an arithmetic reference model.
module tb_fp_normalize;

    localparam int W = 64;
    localparam int E = 11;
    localparam int L = 7;

    logic         clk = 1'b0;
    logic         rst, ce, i_valid, i_ready, o_valid, o_ready, o_zero, o_denorm;
    logic [W-1:0] i_man, o_man;
    logic [E-1:0] i_exp, o_exp;
    logic [L-1:0] o_lz;
`ifdef FP_NORMALIZE_STATS_EN
    logic [31:0]  o_cnt_zero, o_cnt_denorm;
`endif

    always #5 clk = ~clk;

    fp_normalize #(.WID(W), .EXPW(E)) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_man    (i_man),
        .i_exp    (i_exp),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_man    (o_man),
        .o_exp    (o_exp),
        .o_lz     (o_lz),
        .o_zero   (o_zero),
        .o_denorm (o_denorm)
`ifdef FP_NORMALIZE_STATS_EN
        ,
        .o_cnt_zero   (o_cnt_zero),
        .o_cnt_denorm (o_cnt_denorm)
`endif
    );

    typedef struct packed {
        logic [63:0] man;
        logic [10:0] e;
        logic [6:0]  lz;
        logic        z;
        logic        d;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    failures = 0;
    int    popped = 0;
    int    zcnt = 0;
    int    dcnt = 0;

    function automatic beat_t model(logic [63:0] man, logic [10:0] e);
        beat_t r;
        int    lz;
        int    ev;
        int    sh;
        lz = 64;
        ev = int'(e);
        for (int i = 0; i < 64; i++) if (man[i]) lz = 63 - i;
        r = '0;
        if (lz == 64) begin
            r.lz = 7'd64;
            r.z  = 1'b1;
        end else if (lz < ev) begin
            r.man = man << lz;
            r.e   = 11'(ev - lz);
            r.lz  = 7'(lz);
        end else begin
            sh    = (ev == 0) ? 0 : ev - 1;
            r.man = man << sh;
            r.lz  = 7'(sh);
            r.d   = 1'b1;
        end
        return r;
    endfunction

    function automatic beat_t dut_beat();
        beat_t a;
        a.man = o_man;
        a.e   = o_exp;
        a.lz  = o_lz;
        a.z   = o_zero;
        a.d   = o_denorm;
        return a;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard and stall-stability checker, evaluated half a cycle before each active edge.
    beat_t held;
    bit    held_v = 1'b0;
    always @(negedge clk) begin
        beat_t expb;
        if (rst) begin
            sb.delete();
            held_v = 1'b0;
            zcnt   = 0;
            dcnt   = 0;
        end else begin
            if (held_v) begin
                check("stall_valid", 128'(o_valid), 128'(1'b1));
                check("stall_data", 128'(dut_beat()), 128'(held));
            end
            if (o_valid && ce && o_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=none", dut_beat());
                end else begin
                    expb = sb.pop_front();
                    popped++;
                    if (expb.z) zcnt++;
                    if (expb.d) dcnt++;
                    check("out_beat", 128'(dut_beat()), 128'(expb));
                end
            end
            held_v = o_valid && !(ce && o_ready);
            held   = dut_beat();
            if (ce && i_valid && i_ready) sb.push_back(model(i_man, i_exp));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data(output logic [63:0] m, output logic [10:0] e);
        int k;
        m = {$urandom, $urandom};
        k = $urandom_range(0, 64);
        m = (k == 64) ? 64'd0 : (m >> k);
        e = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 70));
    endtask

    task automatic one_beat(input string nm, input logic [63:0] m, input logic [10:0] e, input beat_t req);
        int n;
        ce = 1'b1; o_ready = 1'b1;
        i_valid = 1'b1; i_man = m; i_exp = e;
        step();
        i_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 10) begin
            step();
            n++;
        end
        check({nm, "_latency"}, 128'(n), 128'(3));
        check(nm, 128'(dut_beat()), 128'(req));
        step();
    endtask

    initial begin
        int    sent;
        int    p0;
        bit    saw_full;
        logic [63:0] m;
        logic [10:0] e;

        rst = 1'b1; ce = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
        i_man = '0; i_exp = '0;
        step(); step();
        rst = 1'b0;
        check("rst_o_valid", 128'(o_valid), 128'(0));
        check("rst_outputs", 128'(dut_beat()), 128'(0));
        check("rst_i_ready", 128'(i_ready), 128'(1));

        one_beat("basic", 64'h0000_0001_0000_0000, 11'd100, '{64'h8000_0000_0000_0000, 11'd69, 7'd31, 1'b0, 1'b0});
        one_beat("zero", 64'd0, 11'd500, '{64'd0, 11'd0, 7'd64, 1'b1, 1'b0});
        one_beat("clamp", 64'h0000_0000_0000_00FF, 11'd10, '{64'h0000_0000_0001_FE00, 11'd0, 7'd9, 1'b0, 1'b1});
        one_beat("clamp_e0", 64'h0000_0000_0000_00FF, 11'd0, '{64'h0000_0000_0000_00FF, 11'd0, 7'd0, 1'b0, 1'b1});
        one_beat("lz_eq_exp", 64'h0000_0000_8000_0000, 11'd32, '{64'h4000_0000_0000_0000, 11'd0, 7'd31, 1'b0, 1'b1});
        one_beat("lz_lt_exp", 64'h0000_0000_8000_0000, 11'd33, '{64'h8000_0000_0000_0000, 11'd1, 7'd32, 1'b0, 1'b0});
        one_beat("msb_e0", 64'hF000_0000_0000_0000, 11'd0, '{64'hF000_0000_0000_0000, 11'd0, 7'd0, 1'b0, 1'b1});
        one_beat("msb_e5", 64'hF000_0000_0000_0000, 11'd5, '{64'hF000_0000_0000_0000, 11'd5, 7'd0, 1'b0, 1'b0});

        // Ten-beat stream with the output stalled for cycles 4..8.
        sent = 0; saw_full = 1'b0; p0 = popped;
        for (int c = 0; c < 40; c++) begin
            ce = 1'b1;
            o_ready = !(c >= 4 && c <= 8);
            i_valid = (sent < 10);
            rand_data(m, e);
            i_man = m; i_exp = e;
            @(negedge clk);
            if (i_valid && !i_ready) saw_full = 1'b1;
            if (i_valid && i_ready) sent++;
            step();
        end
        i_valid = 1'b0;
        check("bp_i_ready_fell", 128'(saw_full), 128'(1));
        check("bp_beats_out", 128'(popped - p0), 128'(10));
        check("bp_drained", 128'(sb.size()), 128'(0));

        // Three beats in flight, then a one-cycle reset.
        o_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rand_data(m, e);
            i_valid = 1'b1; i_man = m; i_exp = e;
            step();
        end
        i_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; o_ready = 1'b1;
        check("midrst_o_valid", 128'(o_valid), 128'(0));
        check("midrst_i_ready", 128'(i_ready), 128'(1));
        for (int c = 0; c < 6; c++) step();
        check("midrst_no_stale", 128'(o_valid), 128'(0));

        // Random traffic with random clock-enable and backpressure.
        for (int c = 0; c < 3000; c++) begin
            ce      = ($urandom_range(0, 7) != 0);
            o_ready = ($urandom_range(0, 9) < 7);
            i_valid = ($urandom_range(0, 9) < 7);
            rand_data(m, e);
            i_man = m; i_exp = e;
            step();
        end
        i_valid = 1'b0; ce = 1'b1; o_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) step();
        step();
        check("rand_drained", 128'(sb.size()), 128'(0));
        check("rand_idle", 128'(o_valid), 128'(0));

`ifdef FP_NORMALIZE_STATS_EN
        check("cnt_zero", 128'(o_cnt_zero), 128'(zcnt));
        check("cnt_denorm", 128'(o_cnt_denorm), 128'(dcnt));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_normalize.md
Name: fp_normalize

Overview:
- Pipelined mantissa normalizer that sits directly downstream of the leading-zero counter in the FP datapath.
- Takes an unnormalized mantissa and a biased exponent, counts leading zeros, left-shifts the mantissa, and adjusts the exponent.
- Clamps to denormal when the exponent cannot absorb the full shift.
- Feeds the rounding stage through a valid/ready handshake.

Parameters:
- WID, 64, mantissa width in bits; legal values 16, 32, 64, 128.
- EXPW, 11, biased exponent width in bits.
- LZW, $clog2(WID+1), width of the leading-zero count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  clock enable; when low, all state freezes and handshakes are ignored.
- i_valid  input  1  input beat valid.
- i_ready  output  1  block can accept an input beat.
- i_man  input  WID  unnormalized mantissa.
- i_exp  input  EXPW  biased exponent.
- o_valid  output  1  output beat valid.
- o_ready  input  1  downstream accepts the output beat.
- o_man  output  WID  normalized mantissa.
- o_exp  output  EXPW  adjusted biased exponent.
- o_lz  output  LZW  shift amount actually applied.
- o_zero  output  1  input mantissa was zero.
- o_denorm  output  1  result is clamped denormal.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: every valid bit clears; o_valid=0; o_man, o_exp, o_lz, o_zero, o_denorm all =0; i_ready=1 on the cycle after rst deasserts.
- Pipeline has three stages:
  - S1: registers i_man and i_exp.
  - S2: leading-zero count lz of S1 mantissa, range 0..WID, registered with the mantissa and exponent.
  - S3: shift and exponent adjust, registered onto the outputs.
- Latency: 3 cycles from input accept to o_valid when never stalled. Throughput is 1 beat per cycle.
- Handshake:
  - Input beat accepted when i_valid & i_ready & ce.
  - Output beat consumed when o_valid & o_ready & ce.
  - Each stage loads when it is empty or its contents move on in the same cycle.
  - i_ready = !S1_valid | S1_advances. It is combinational from o_ready through the stage chain; no registered skid buffer.
  - Output data holds stable while o_valid & !o_ready.
  - Bubbles compress: a stalled output does not block upstream stages that are empty.
- Arithmetic, in priority order:
  - Zero mantissa (lz==WID): o_man=0, o_exp=0, o_lz=WID, o_zero=1, o_denorm=0.
  - Normal case (lz < i_exp): o_man = man << lz; o_exp = i_exp - lz; o_lz = lz; o_denorm=0.
  - Clamp case (lz >= i_exp): sh = (i_exp==0) ? 0 : i_exp-1; o_man = man << sh; o_exp = 0; o_lz = sh; o_denorm=1.
- Width rules: exponent subtraction is done in EXPW+1 bits, and the sign bit selects the clamp case. The shift is logical left with zero fill.
- Simultaneous accept and consume in one cycle with all stages full: no stall, no beat lost or duplicated.
- Reset mid-operation: all in-flight beats are discarded and no partial output is presented.
- ce low with rst high: reset still takes effect, because reset has priority over ce.

Optional Feature:
- Macro: FP_NORMALIZE_STATS_EN.
- With the macro defined, the block adds:
  - Outputs o_cnt_zero[31:0] and o_cnt_denorm[31:0].
  - Each counter increments on every consumed output beat with o_zero or o_denorm set, respectively.
  - Counters saturate at 32'hFFFFFFFF and clear on rst.
- Without the macro, these ports and counters do not exist, and the remaining behaviour is identical.

Decomposition:
- Shared package fp_norm_pkg holds:
  - the stage payload typedef struct {man, exp, lz, zero, denorm};
  - localparams for the default WID, EXPW and LZW.
- One sub-module, fp_norm_lzc: combinational parameterized leading-zero counter of width WID, instantiated in S2.
- The shift, exponent adjust and handshake logic stay in the top module.

Test Plan:
- Single beat, WID=64, EXPW=11: i_man=64'h0000_0001_0000_0000, i_exp=100 -> after 3 cycles o_man=64'h8000_0000_0000_0000, o_exp=69, o_lz=31, o_zero=0, o_denorm=0.
- Zero input: i_man=0, i_exp=500 -> o_man=0, o_exp=0, o_lz=64, o_zero=1.
- Clamp case: i_man=64'h0000_0000_0000_00FF, i_exp=10 -> lz=56 >= 10, so o_lz=9, o_man=64'h0000_0000_0001_FE00, o_exp=0, o_denorm=1. Also i_exp=0 -> o_lz=0, o_man unchanged, o_denorm=1.
- Backpressure: stream 10 beats with o_ready low for cycles 4-8 -> i_ready falls once all three stages are full; all 10 beats emerge in order, no loss or duplication; output data stays stable during the stall.
- Mid-stream reset: 3 beats in flight, assert rst for 1 cycle -> o_valid=0 the next cycle, no stale beat ever appears, i_ready=1.
- FP_NORMALIZE_STATS_EN: 5 zero beats and 3 denorm beats consumed -> o_cnt_zero=5, o_cnt_denorm=3; forcing a counter to the saturation value and adding a beat leaves it at 32'hFFFFFFFF.
